serial_stream_buffer: RTL and testbench

Parametrised serial-to-parallel receive path. It assembles a bit stream into WIDTH-bit words, supports configurable bit order, and pushes completed words into an internal DEPTH-entry FIFO. It applies backpressure to the bit source when the FIFO is full. It sits between a single-bit serial producer and a word-level consumer, and supersedes the fixed 8-bit deserializer/queue pair in `top`.

---
 rtl/serial_stream_buffer.sv | 160 ++++++++++++++++
 tb/tb_serial_stream_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_stream_buffer.sv
// serial_stream_buffer: bit-serial receive path that assembles WIDTH-bit words into a DEPTH-entry FIFO.
// Define SSB_PARITY_EN to require an even-parity bit after each word; failing words are discarded.
module serial_stream_buffer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  output logic                       status_out,
  output logic                       data_ready,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       parity_err_out
);

  localparam int unsigned LEN_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SSB_PARITY_EN
  typedef enum logic [1:0] {S_COLLECT = 2'd0, S_PARITY = 2'd1, S_HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_COLLECT = 2'd0, S_HOLD = 2'd2} state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]  r_word;
  logic [WIDTH-1:0]  w_word_nxt;
  logic [WIDTH-1:0]  w_shifted;
  logic              w_push;
  logic              w_pop;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LEN_W-1:0]  r_len;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_data_ready;
`ifdef SSB_PARITY_EN
  logic              w_par_err;
  logic              r_parity_err;
`endif

  // Incoming bit enters at the end that leaves the first bit at its required position.
  assign w_shifted = MSB_FIRST ? {r_word[WIDTH-2:0], data_in} : {data_in, r_word[WIDTH-1:1]};

  // Deserializer next-state and FIFO push/pop decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_push      = 1'b0;
`ifdef SSB_PARITY_EN
    w_par_err   = 1'b0;
`endif
    case (r_state)
      S_COLLECT: begin
        if (write_in) begin
          w_word_nxt = w_shifted;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
`ifdef SSB_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_HOLD;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
`ifdef SSB_PARITY_EN
      S_PARITY: begin
        if (write_in) begin
          if (^{r_word, data_in}) begin
            w_par_err   = 1'b1;
            w_state_nxt = S_COLLECT;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
`endif
      S_HOLD: begin
        // Occupancy is the registered value, so a same-cycle pop does not make room.
        if (r_len != LEN_FULL) begin
          w_push      = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
    w_pop = dequeue_in && (r_len != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_COLLECT;
      r_cnt        <= '0;
      r_word       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
      r_data_out   <= '0;
      r_data_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_word       <= w_word_nxt;
      r_data_ready <= w_push;
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_len <= r_len + LEN_W'(1);
        2'b01:   r_len <= r_len - LEN_W'(1);
        default: r_len <= r_len;
      endcase
    end
  end

  // FIFO storage; pointers carry the reset, the array does not need one.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= r_word;
    end
  end

`ifdef SSB_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_err;
    end
  end
  assign parity_err_out = r_parity_err;
`else
  assign parity_err_out = 1'b0;
`endif

  assign status_out = (r_state != S_HOLD);
  assign data_ready = r_data_ready;
  assign data_out   = r_data_out;
  assign len_out    = r_len;

endmodule

// File: tb/tb_serial_stream_buffer.sv
// Bench for serial_stream_buffer: MSB-first and LSB-first instances share stimulus and are
// compared against a queue-based reference model, plus a vector table and directed sequences.
module tb_serial_stream_buffer;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int LEN_W = $clog2(D + 1);
`ifdef SSB_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             data_in = 1'b0;
  logic             write_in = 1'b0;
  logic             dequeue_in = 1'b0;
  logic             m_status, m_ready, m_perr;
  logic [W-1:0]     m_dout;
  logic [LEN_W-1:0] m_len;
  logic             l_status, l_ready, l_perr;
  logic [W-1:0]     l_dout;
  logic [LEN_W-1:0] l_len;

  always #5 clock = ~clock;

  serial_stream_buffer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(m_status), .data_ready(m_ready), .dequeue_in(dequeue_in),
    .data_out(m_dout), .len_out(m_len), .parity_err_out(m_perr)
  );

  serial_stream_buffer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(l_status), .data_ready(l_ready), .dequeue_in(dequeue_in),
    .data_out(l_dout), .len_out(l_len), .parity_err_out(l_perr)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: accepted bits, a pending word, and the FIFO as queues.
  bit           bits[$];
  logic [W-1:0] q_m[$];
  logic [W-1:0] q_l[$];
  bit           holding = 1'b0;
  logic [W-1:0] pend_m = '0;
  logic [W-1:0] pend_l = '0;
  logic [W-1:0] exp_dout_m = '0;
  logic [W-1:0] exp_dout_l = '0;
  bit           exp_ready = 1'b0;
  bit           exp_perr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] assemble(input bit msb_first);
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) v[W-1-i] = bits[i];
      else           v[i]     = bits[i];
    end
    return v;
  endfunction

  task automatic model_step(input bit d, input bit w, input bit q, input bit r);
    int  pre;
    bit  push;
    int  ones;
    if (r) begin
      holding = 1'b0; bits.delete(); q_m.delete(); q_l.delete();
      exp_dout_m = '0; exp_dout_l = '0; exp_ready = 1'b0; exp_perr = 1'b0;
      return;
    end
    pre       = q_m.size();
    push      = holding && (pre < D);
    exp_ready = push;
    exp_perr  = 1'b0;
    if (q && pre > 0) begin
      exp_dout_m = q_m.pop_front();
      exp_dout_l = q_l.pop_front();
    end
    if (push) begin
      q_m.push_back(pend_m);
      q_l.push_back(pend_l);
      holding = 1'b0;
    end else if (!holding && w) begin
      bits.push_back(d);
      if (bits.size() == W + NPAR) begin
        ones = 0;
        foreach (bits[i]) ones += int'(bits[i]);
        if (NPAR == 1 && (ones % 2) != 0) begin
          exp_perr = 1'b1;
        end else begin
          holding = 1'b1;
          pend_m  = assemble(1'b1);
          pend_l  = assemble(1'b0);
        end
        bits.delete();
      end
    end
  endtask

  task automatic check_model();
    chk("model status msb", 32'(m_status), 32'(!holding));
    chk("model status lsb", 32'(l_status), 32'(!holding));
    chk("model data_ready", 32'(m_ready), 32'(exp_ready));
    chk("model data_ready lsb", 32'(l_ready), 32'(exp_ready));
    chk("model data_out msb", 32'(m_dout), 32'(exp_dout_m));
    chk("model data_out lsb", 32'(l_dout), 32'(exp_dout_l));
    chk("model len msb", 32'(m_len), 32'(q_m.size()));
    chk("model len lsb", 32'(l_len), 32'(q_l.size()));
    chk("model parity_err", 32'(m_perr), 32'(exp_perr));
    chk("model parity_err lsb", 32'(l_perr), 32'(exp_perr));
  endtask

  // Drive one cycle, advance the model with the edge, and check #1 after the edge.
  task automatic tick(input bit d, input bit w, input bit q, input bit r);
    data_in = d; write_in = w; dequeue_in = q; reset = r;
    @(posedge clock);
    model_step(d, w, q, r);
    #1;
    check_model();
  endtask

  task automatic send_data(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) tick(v[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] v);
    send_data(v);
`ifdef SSB_PARITY_EN
    tick(^v, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  typedef struct {
    bit               din, wr, deq, rst;
    bit               st, rdy;
    logic [W-1:0]     dm, dl;
    logic [LEN_W-1:0] len;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit din, input bit wr, input bit deq, input bit rst,
                              input bit st, input bit rdy, input logic [W-1:0] dm,
                              input logic [W-1:0] dl, input logic [LEN_W-1:0] len);
    vec_t v;
    v.din = din; v.wr = wr; v.deq = deq; v.rst = rst;
    v.st = st; v.rdy = rdy; v.dm = dm; v.dl = dl; v.len = len;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [W-1:0] pat;
    int           dq_mod;

    // Vector table: bits 0,1,0,1,0,0,1,0 give 0x52 MSB-first and 0x4A LSB-first.
    pat = 8'h52;
    add(0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0);
    for (int i = W - 1; i >= 0; i--)
      add(pat[i], 1, 0, 0, (i != 0) || (NPAR == 1), 0, 8'h00, 8'h00, 0);
`ifdef SSB_PARITY_EN
    add(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0);
`endif
    add(0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 1);
    add(0, 0, 1, 0, 1, 0, 8'h52, 8'h4A, 0);
    add(0, 0, 1, 0, 1, 0, 8'h52, 8'h4A, 0);
    foreach (tbl[k]) begin
      tick(tbl[k].din, tbl[k].wr, tbl[k].deq, tbl[k].rst);
      chk("vec status", 32'(m_status), 32'(tbl[k].st));
      chk("vec data_ready", 32'(m_ready), 32'(tbl[k].rdy));
      chk("vec data_out msb", 32'(m_dout), 32'(tbl[k].dm));
      chk("vec data_out lsb", 32'(l_dout), 32'(tbl[k].dl));
      chk("vec len", 32'(m_len), 32'(tbl[k].len));
    end

    // Fill to DEPTH, then a fifth word waits in HOLD until a pop frees a slot.
    tick(0, 0, 0, 1);
    send_word(8'h11); tick(0, 0, 0, 0);
    send_word(8'h22); tick(0, 0, 0, 0);
    send_word(8'h33); tick(0, 0, 0, 0);
    send_word(8'h44); tick(0, 0, 0, 0);
    send_word(8'h55);
    tick(1, 1, 0, 0);
    chk("full hold status", 32'(m_status), 32'd0);
    chk("full hold len", 32'(m_len), 32'd4);
    tick(0, 0, 1, 0);
    chk("full pop data", 32'(m_dout), 32'h11);
    chk("full pop status", 32'(m_status), 32'd0);
    tick(0, 0, 0, 0);
    chk("deferred push len", 32'(m_len), 32'd4);
    chk("deferred push ready", 32'(m_ready), 32'd1);
    tick(0, 0, 1, 0); chk("drain 0x22", 32'(m_dout), 32'h22);
    tick(0, 0, 1, 0); chk("drain 0x33", 32'(m_dout), 32'h33);
    tick(0, 0, 1, 0); chk("drain 0x44", 32'(m_dout), 32'h44);
    tick(0, 0, 1, 0); chk("drain 0x55", 32'(m_dout), 32'h55);
    chk("drain len", 32'(m_len), 32'd0);

    // Push and pop on the same edge with two words queued.
    tick(0, 0, 0, 1);
    send_word(8'h21); tick(0, 0, 0, 0);
    send_word(8'h42); tick(0, 0, 0, 0);
    send_word(8'h63);
    tick(0, 0, 1, 0);
    chk("push+pop len", 32'(m_len), 32'd2);
    chk("push+pop data", 32'(m_dout), 32'h21);
    tick(0, 0, 1, 0); chk("order 0x42", 32'(m_dout), 32'h42);
    tick(0, 0, 1, 0); chk("order 0x63", 32'(m_dout), 32'h63);
    tick(0, 0, 1, 0); chk("pop empty data", 32'(m_dout), 32'h63);
    chk("pop empty len", 32'(m_len), 32'd0);

    // Reset after 5 of 8 bits clears FIFO and partial word.
    send_word(8'h77); tick(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
    tick(0, 0, 0, 1);
    chk("reset len", 32'(m_len), 32'd0);
    chk("reset status", 32'(m_status), 32'd1);
    chk("reset data_out", 32'(m_dout), 32'd0);
    send_word(8'h5A); tick(0, 0, 0, 0);
    chk("clean word len", 32'(m_len), 32'd1);
    tick(0, 0, 1, 0);
    chk("clean word data", 32'(m_dout), 32'h5A);

`ifdef SSB_PARITY_EN
    // 0x53 has four ones, so parity 1 is wrong; 0x52 has three, so parity 1 is right.
    tick(0, 0, 0, 1);
    send_data(8'h53);
    tick(1, 1, 0, 0);
    chk("parity err pulse", 32'(m_perr), 32'd1);
    chk("parity err len", 32'(m_len), 32'd0);
    tick(0, 0, 0, 0);
    chk("parity err clears", 32'(m_perr), 32'd0);
    chk("parity err no push", 32'(m_len), 32'd0);
    send_data(8'h52);
    tick(1, 1, 0, 0);
    chk("parity ok no err", 32'(m_perr), 32'd0);
    tick(0, 0, 0, 0);
    chk("parity ok len", 32'(m_len), 32'd1);
`endif

    // Random traffic: slow draining first to reach full, then fast draining.
    tick(0, 0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      dq_mod = (c < 1500) ? 16 : 2;
      tick(1'($urandom % 2), ($urandom % 4) != 0, ($urandom % dq_mod) == 0,
           ($urandom % 700) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
